// File: rtl/master_external_ctrl.sv
// -----------------------------------------------------------------------------
// master_external_ctrl
//
// Bus-master front end. A one-cycle `start` requests the bus from the arbiter.
// Once the grant is held for two consecutive edges, the block shifts a control
// frame out on `control`, MSB first. It then moves one serial data word to or
// from the addressed slave. Data bits are gated by the slave's `ready`. The
// result is held on `doneCom`/`dataOut` for a display period.
//
// Control frame (MSB first): START(1) | SLAVE_ID[2:0] | RW | BURST(0) | ADDRESS[12:0]
//
// Optional build macro: MASTER_CTRL_PARITY_EN
//   When it is defined, an even-parity bit is appended to the control frame,
//   making it 20 bits. One parity bit also follows the data word. For a read
//   the parity bit is checked, and a mismatch ends with doneCom=11. For a write
//   the parity bit is driven.
//   When it is undefined, the frame is 19 bits and there is no parity bit.
//
// Ports:
//   clk      in   system clock, rising edge
//   rstN     in   asynchronous active-low reset
//   start    in   one-cycle transaction request (honoured only in IDLE)
//   eoc      in   abort request (honoured in REQ/CTRL/XFER)
//   doneCom  out  status: 00 idle, 01 busy, 10 done, 11 aborted
//   dataOut  out  last word read (RW=0) or written (RW=1)
//   rD       in   serial read data from slave
//   ready    in   slave ready; data bits move only when high
//   control  out  serial control frame, idle low
//   wrD      out  serial write data to slave
//   valid    out  high while wrD carries write bits
//   arbCont  in   arbiter grant
//   arbSend  out  bus request to arbiter
// -----------------------------------------------------------------------------
module master_external_ctrl #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    CLK_FREQ       = 5,
    parameter int                    CLOCK_DURATION = 1,
    parameter logic [2:0]            SLAVE_ID       = 3'd1,
    parameter logic [12:0]           ADDRESS        = 13'd0,
    parameter logic                  RW             = 1'b0,
    parameter logic [DATA_WIDTH-1:0] WRITE_DATA     = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  start,
    input  logic                  eoc,
    output logic [1:0]            doneCom,
    output logic [DATA_WIDTH-1:0] dataOut,
    input  logic                  rD,
    input  logic                  ready,
    output logic                  control,
    output logic                  wrD,
    output logic                  valid,
    input  logic                  arbCont,
    output logic                  arbSend
);

    localparam logic [18:0] FRAME_BASE = {1'b1, SLAVE_ID, RW, 1'b0, ADDRESS};

`ifdef MASTER_CTRL_PARITY_EN
    localparam int   PAR_BITS = 1;
    localparam logic PAR_EN   = 1'b1;
    localparam logic [19:0] FRAME = {FRAME_BASE, ^FRAME_BASE};
    localparam logic [DATA_WIDTH:0] WR_WORD = {WRITE_DATA, ^WRITE_DATA};
`else
    localparam int   PAR_BITS = 0;
    localparam logic PAR_EN   = 1'b0;
    localparam logic [18:0] FRAME = FRAME_BASE;
    localparam logic [DATA_WIDTH-1:0] WR_WORD = WRITE_DATA;
`endif

    localparam int FRAME_LEN = 19 + PAR_BITS;
    localparam int XFER_LEN  = DATA_WIDTH + PAR_BITS;
    localparam int HOLD_CYC  = (CLK_FREQ * CLOCK_DURATION > 0) ? CLK_FREQ * CLOCK_DURATION : 1;

    // One counter is shared by the CTRL, XFER and DONE phases, so it is sized
    // for the longest of the three.
    localparam int CNT_MAX = (FRAME_LEN > XFER_LEN)
                           ? ((FRAME_LEN > HOLD_CYC) ? FRAME_LEN : HOLD_CYC)
                           : ((XFER_LEN  > HOLD_CYC) ? XFER_LEN  : HOLD_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] XFER_LAST  = CW'(XFER_LEN - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CTRL,
        XFER,
        DONE,
        ABORT
    } state_t;

    state_t                  state_q,  state_d;
    logic [CW-1:0]           cnt_q,    cnt_d;
    logic                    gnt_q,    gnt_d;     // one grant high already seen
    logic [FRAME_LEN-1:0]    frame_q,  frame_d;
    logic [XFER_LEN-1:0]     wr_q,     wr_d;
    logic [XFER_LEN-1:0]     rx_q,     rx_d;
    logic [DATA_WIDTH-1:0]   data_q,   data_d;
    logic                    err_q,    err_d;     // read parity mismatch

    // Receive word including the bit being accepted on this edge.
    logic [XFER_LEN-1:0]     rx_word;
    assign rx_word = {rx_q[XFER_LEN-2:0], rD};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 1'b0;
            frame_q <= '0;
            wr_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            frame_q <= frame_d;
            wr_q    <= wr_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        frame_d = frame_q;
        wr_d    = wr_q;
        rx_d    = rx_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    gnt_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end

            REQ: begin
                if (eoc) begin
                    state_d = ABORT;
                    gnt_d   = 1'b0;
                end else if (arbCont) begin
                    if (gnt_q) begin
                        state_d = CTRL;
                        gnt_d   = 1'b0;
                        cnt_d   = '0;
                        frame_d = FRAME;
                    end else begin
                        gnt_d = 1'b1;
                    end
                end else begin
                    // A low grant breaks the consecutive run.
                    gnt_d = 1'b0;
                end
            end

            CTRL: begin
                // The frame is clocked out unconditionally; ready is not consulted.
                if (eoc) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else begin
                    frame_d = frame_q << 1;
                    if (cnt_q == FRAME_LAST) begin
                        state_d = XFER;
                        cnt_d   = '0;
                        wr_d    = WR_WORD;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            XFER: begin
                if (eoc) begin
                    state_d = ABORT;
                    cnt_d   = '0;
                end else if (ready) begin
                    rx_d = rx_word;
                    wr_d = wr_q << 1;
                    if (cnt_q == XFER_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        data_d  = RW ? WRITE_DATA : rx_word[XFER_LEN-1 -: DATA_WIDTH];
                        // Even parity: the XOR over data and parity bit must be 0.
                        err_d   = PAR_EN & ~RW & (^rx_word);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            DONE: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ABORT: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = 1'b0;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                gnt_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        doneCom = 2'b00;
        arbSend = 1'b0;
        control = 1'b0;
        valid   = 1'b0;
        wrD     = 1'b0;

        case (state_q)
            REQ: begin
                doneCom = 2'b01;
                arbSend = 1'b1;
            end
            CTRL: begin
                doneCom = 2'b01;
                arbSend = 1'b1;
                control = frame_q[FRAME_LEN-1];
            end
            XFER: begin
                doneCom = 2'b01;
                arbSend = 1'b1;
                valid   = RW;
                wrD     = RW & wr_q[XFER_LEN-1];
            end
            DONE:    doneCom = err_q ? 2'b11 : 2'b10;
            ABORT:   doneCom = 2'b11;
            default: doneCom = 2'b00;
        endcase
    end

    assign dataOut = data_q;

endmodule

// File: tb/tb_master_external_ctrl.sv
// -----------------------------------------------------------------------------
// tb_master_external_ctrl
//
// Two instances share all of their inputs and run in lockstep. u_rd is the read
// master (RW=0) and u_wr is the write master (RW=1). Every cycle, the expected
// outputs are worked out from the transaction phase that the bench is driving:
//   - the frame bits, built from the field layout
//   - the grant, from a count of consecutive highs
//   - the data bits, from the index of the accepted bit
// -----------------------------------------------------------------------------
module tb_master_external_ctrl;

    localparam logic [2:0]  SID   = 3'd1;
    localparam logic [12:0] ADDR  = 13'd0;
    localparam logic [7:0]  WDATA = 8'hA5;
    localparam int          HOLD  = 5;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       start = 1'b0;
    logic       eoc = 1'b0;
    logic       rD = 1'b0;
    logic       ready = 1'b0;
    logic       arbCont = 1'b0;

    logic [1:0] dc_rd, dc_wr;
    logic [7:0] do_rd, do_wr;
    logic       ctl_rd, ctl_wr, wrd_rd, wrd_wr, vld_rd, vld_wr, arb_rd, arb_wr;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_rd_data = 8'h00;
    logic [7:0] exp_wr_data = 8'h00;

    master_external_ctrl #(
        .DATA_WIDTH(8), .CLK_FREQ(5), .CLOCK_DURATION(1),
        .SLAVE_ID(SID), .ADDRESS(ADDR), .RW(1'b0), .WRITE_DATA(WDATA)
    ) u_rd (
        .clk(clk), .rstN(rstN), .start(start), .eoc(eoc),
        .doneCom(dc_rd), .dataOut(do_rd), .rD(rD), .ready(ready),
        .control(ctl_rd), .wrD(wrd_rd), .valid(vld_rd),
        .arbCont(arbCont), .arbSend(arb_rd)
    );

    master_external_ctrl #(
        .DATA_WIDTH(8), .CLK_FREQ(5), .CLOCK_DURATION(1),
        .SLAVE_ID(SID), .ADDRESS(ADDR), .RW(1'b1), .WRITE_DATA(WDATA)
    ) u_wr (
        .clk(clk), .rstN(rstN), .start(start), .eoc(eoc),
        .doneCom(dc_wr), .dataOut(do_wr), .rD(rD), .ready(ready),
        .control(ctl_wr), .wrD(wrd_wr), .valid(vld_wr),
        .arbCont(arbCont), .arbSend(arb_wr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame as laid out by field: START | SLAVE_ID | RW | BURST | ADDRESS.
    function automatic logic [18:0] frame_of(input logic rw);
        return {1'b1, SID, rw, 1'b0, ADDR};
    endfunction

    task automatic expect_all(input string tag, input logic [1:0] dc, input logic arb,
                              input logic c_rd, input logic c_wr,
                              input logic v_wr, input logic w_wr);
        chk({tag, ".rd.doneCom"}, 32'(dc_rd),  32'(dc));
        chk({tag, ".rd.arbSend"}, 32'(arb_rd), 32'(arb));
        chk({tag, ".rd.control"}, 32'(ctl_rd), 32'(c_rd));
        chk({tag, ".rd.valid"},   32'(vld_rd), 32'(1'b0));
        chk({tag, ".rd.wrD"},     32'(wrd_rd), 32'(1'b0));
        chk({tag, ".rd.dataOut"}, 32'(do_rd),  32'(exp_rd_data));
        chk({tag, ".wr.doneCom"}, 32'(dc_wr),  32'(dc));
        chk({tag, ".wr.arbSend"}, 32'(arb_wr), 32'(arb));
        chk({tag, ".wr.control"}, 32'(ctl_wr), 32'(c_wr));
        chk({tag, ".wr.valid"},   32'(vld_wr), 32'(v_wr));
        chk({tag, ".wr.wrD"},     32'(wrd_wr), 32'(w_wr));
        chk({tag, ".wr.dataOut"}, 32'(do_wr),  32'(exp_wr_data));
    endtask

    // eoc held for one edge: one ABORT cycle reporting 11, then idle.
    task automatic do_abort(input string tag);
        start = 1'b0;
        eoc   = 1'b1;
        tick();
        eoc   = 1'b0;
        expect_all({tag, ".abort"}, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all({tag, ".post_abort"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // grant_mode: 0 = 1,1  1 = 1,0,1,1  2 = random prefix then 1,1
    // rdy_mode:   0 = always ready  1 = 3 ready / 100 stalled / ready  2 = random
    // abort_ph:   0 none, 1 eoc at CTRL bit, 2 eoc at XFER cycle, 3 eoc at REQ cycle,
    //             4 reset at CTRL bit
    task automatic run_txn(input string name, input logic [7:0] word, input int grant_mode,
                           input int rdy_mode, input int abort_ph, input int abort_idx);
        logic [18:0] f_rd;
        logic [18:0] f_wr;
        logic [7:0]  wd;
        logic        gq[$];
        int          consec;
        int          k;
        int          acc;
        int          cyc;

        f_rd = frame_of(1'b0);
        f_wr = frame_of(1'b1);
        wd   = WDATA;
        gq   = {};
        if (grant_mode == 1) begin
            gq.push_back(1'b1); gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b1);
        end else if (grant_mode == 2) begin
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) gq.push_back(1'($urandom));
            gq.push_back(1'b1); gq.push_back(1'b1);
        end else begin
            gq.push_back(1'b1); gq.push_back(1'b1);
        end

        expect_all({name, ".idle0"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        eoc   = 1'b0;
        tick();
        start = 1'b0;

        consec = 0;
        k      = 0;
        while (consec < 2 && k < 40) begin
            expect_all({name, ".req"}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            arbCont = (k < gq.size()) ? gq[k] : 1'b1;
            start   = 1'($urandom);
            if (abort_ph == 3 && k == abort_idx) begin
                do_abort(name);
                arbCont = 1'b0;
                return;
            end
            tick();
            consec = arbCont ? consec + 1 : 0;
            k++;
        end
        chk({name, ".grant_run"}, 32'(consec), 32'd2);

        for (int i = 0; i < 19; i++) begin
            expect_all({name, ".ctrl"}, 2'b01, 1'b1, f_rd[18-i], f_wr[18-i], 1'b0, 1'b0);
            ready   = 1'($urandom);
            rD      = 1'($urandom);
            arbCont = 1'($urandom);
            start   = 1'($urandom);
            if (abort_ph == 1 && i == abort_idx) begin
                do_abort(name);
                return;
            end
            if (abort_ph == 4 && i == abort_idx) begin
                start = 1'b0;
                #2;
                rstN = 1'b0;
                #1;
                exp_rd_data = 8'h00;
                exp_wr_data = 8'h00;
                expect_all({name, ".async_rst"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                @(negedge clk);
                rstN = 1'b1;
                tick();
                expect_all({name, ".rst_idle"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                return;
            end
            tick();
        end

        acc = 0;
        cyc = 0;
        while (acc < 8 && cyc < 400) begin
            expect_all({name, ".xfer"}, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, wd[7-acc]);
            case (rdy_mode)
                0:       ready = 1'b1;
                1:       ready = (cyc < 3 || cyc >= 103);
                default: ready = (cyc == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
            endcase
            rD      = ready ? word[7-acc] : 1'($urandom);
            start   = 1'($urandom);
            arbCont = 1'($urandom);
            if (abort_ph == 2 && cyc == abort_idx) begin
                do_abort(name);
                return;
            end
            tick();
            if (ready) acc++;
            cyc++;
        end
        chk({name, ".xfer_bits"}, 32'(acc), 32'd8);

        exp_rd_data = word;
        exp_wr_data = wd;
        for (int h = 0; h < HOLD; h++) begin
            expect_all({name, ".done"}, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            eoc   = 1'($urandom);
            start = 1'($urandom);
            ready = 1'($urandom);
            tick();
        end
        start = 1'b0;
        eoc   = 1'b1;
        expect_all({name, ".idle1"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        eoc = 1'b0;
        expect_all({name, ".idle2"}, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset, with start pulsed while reset is held.
        rstN  = 1'b0;
        start = 1'b1;
        tick();
        expect_all("reset_a", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        tick();
        expect_all("reset_b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rstN = 1'b1;
        tick();
        expect_all("post_reset_a", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        expect_all("post_reset_b", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_txn("read_ff",    8'hFF, 0, 0, 0, 0);
        run_txn("stall_b3",   8'hB3, 0, 1, 0, 0);
        run_txn("glitch",     8'($urandom), 1, 2, 0, 0);
        run_txn("write_rnd",  8'($urandom), 0, 2, 0, 0);
        run_txn("abort_ctrl", 8'($urandom), 0, 0, 1, 7);
        run_txn("abort_req",  8'($urandom), 0, 0, 3, 0);
        run_txn("abort_xfer", 8'($urandom), 0, 2, 2, 3);
        for (int t = 0; t < 4; t++) begin
            run_txn("random", 8'($urandom), 2, 2, 0, 0);
        end
        run_txn("reset_mid",  8'($urandom), 0, 0, 4, 10);
        run_txn("recover",    8'h3C, 1, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/master_external_ctrl.md
Name: master_external_ctrl

Overview:
- Bus-master front end between the top module and the serial bus. A `start` pulse makes it request the bus from the arbiter and, once granted, serialise a 19-bit control frame.
- It then performs one serial read or write word transfer with the addressed slave, gated by the slave's `ready`.
- It reports status on `doneCom`, shows the transferred word on `dataOut`, and holds the result for a display period.

Parameters:
- DATA_WIDTH, 8, width of one data word and of `dataOut`.
- CLK_FREQ, 5, display-period multiplier (clock cycles per unit).
- CLOCK_DURATION, 1, display-period units; the result is held for CLK_FREQ*CLOCK_DURATION cycles (5).
- SLAVE_ID, 3'd1, 3-bit target slave id placed in the control frame.
- ADDRESS, 13'd0, 13-bit slave address placed in the control frame.
- RW, 1'b0, 0 = read from slave, 1 = write to slave.
- WRITE_DATA, 8'hA5, word sent when RW=1.

Ports:
- clk  in  1  system clock, rising edge.
- rstN  in  1  reset; asynchronous and active-low.
- start  in  1  one-cycle request from the top module to begin a transaction.
- eoc  in  1  end-of-communication/abort from the top module.
- doneCom  out  2  status: 00 idle, 01 busy, 10 done, 11 aborted.
- dataOut  out  DATA_WIDTH  last word read (RW=0) or written (RW=1).
- rD  in  1  serial read data from slave.
- ready  in  1  slave ready; a bit moves only on cycles where it is 1.
- control  out  1  serial control frame, idle 0.
- wrD  out  1  serial write data to slave.
- valid  out  1  high while `wrD` carries write bits.
- arbCont  in  1  arbiter grant line.
- arbSend  out  1  bus request to the arbiter.

Behaviour:
- Reset (async, rstN=0): state IDLE; doneCom=00, dataOut=0, control=0, wrD=0, valid=0, arbSend=0; all counters cleared. `start` is ignored while rstN=0.
- States: IDLE, REQ, CTRL, XFER, DONE, ABORT.
- IDLE: `start`=1 at a rising edge → REQ. doneCom=00.
- REQ:
  - arbSend=1, doneCom=01.
  - Grant = arbCont sampled 1 on 2 consecutive edges. A 0 resets the consecutive count.
  - On grant → CTRL. arbSend stays 1 until DONE or ABORT.
- CTRL:
  - Shifts the frame out MSB first, one bit per clock, 19 cycles, regardless of `ready`.
  - Frame order: START(1'b1) | SLAVE_ID[2:0] | RW | B(1'b0, no burst) | ADDRESS[12:0].
  - After the 19th bit, control returns to 0 → XFER.
- XFER read (RW=0):
  - On each edge with ready=1, shift rD into a shift register, MSB first.
  - After DATA_WIDTH accepted bits, load dataOut → DONE.
  - ready=0 stalls indefinitely with no timeout.
- XFER write (RW=1):
  - valid=1; wrD presents WRITE_DATA bit i, MSB first.
  - The bit index advances on each edge with ready=1.
  - After DATA_WIDTH accepted bits: valid=0, dataOut=WRITE_DATA → DONE.
- DONE:
  - arbSend=0, doneCom=10.
  - dataOut holds for CLK_FREQ*CLOCK_DURATION cycles, then → IDLE. dataOut keeps its value in IDLE until the next completion.
- eoc=1 in REQ/CTRL/XFER → ABORT (same edge priority over all other transitions).
  - ABORT: control/wrD/valid/arbSend=0, doneCom=11 for one cycle → IDLE.
  - eoc is ignored in IDLE/DONE.
- `start` in any non-IDLE state is ignored.
- Reset asserted mid-transaction returns everything to reset values immediately.

Optional Feature:
- Macro MASTER_CTRL_PARITY_EN.
- Defined: an even-parity bit over the 19 frame bits is appended, so CTRL lasts 20 cycles. During XFER, parity is checked on the received word (read) or driven after the data (write), gated by ready like data bits. A read parity mismatch ends in doneCom=11 instead of 10.
- Undefined: 19-bit frame and no parity bit.

Test Plan:
- Reset with `start` pulsed while rstN=0 → all outputs 0, state stays IDLE after rstN=1.
- Read: start, arbCont=1 for 2 cycles → arbSend=1 from cycle after start, control emits 1,001,0,0,13'd0 over 19 cycles. rD=1 with ready=1 for 8 cycles → dataOut=8'hFF, doneCom=10 for 5 cycles, then 00, arbSend=0.
- Ready stall: ready toggles 1 (3 cycles), 0 (100 cycles), 1 (5 cycles) with rD pattern 10110011 → dataOut=8'hB3 only after 8 accepted bits, doneCom=01 throughout the stall.
- Grant glitch: arbCont 1,0,1,1 → CTRL begins only after the final two highs.
- Write (RW=1): after grant, wrD emits A5 MSB first with valid=1; a ready=0 cycle repeats the bit → dataOut=8'hA5, doneCom=10.
- Abort: eoc=1 at frame bit 7 → control=0, arbSend=0, doneCom=11 one cycle, then 00.
